product_accumulator: RTL

- Consumer stage placed directly after the sequential 8x8 multiplier.
- Takes each 16-bit product through a valid/ready handshake and sums a fixed number of them (N_TERMS) into a wide accumulator.
- Presents the finished sum to the next stage through a second valid/ready handshake.
- Tracks overflow, and supports synchronous clear between batches.

---
 rtl/product_accumulator.sv | 101 ++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// Sums N_TERMS 16-bit products into an ACC_W-bit accumulator and hands the result on through a valid/ready handshake.
// Define PRODUCT_ACC_SATURATE_EN to clamp on overflow; otherwise the accumulator wraps.
module product_accumulator #(
    parameter int ACC_W   = 24,
    parameter int N_TERMS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [15:0]      c_in,
    input  logic             c_valid,
    output logic             c_ready,
    output logic [ACC_W-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [2:0]       term_cnt,
    output logic             overflow
);

    typedef enum logic {S_ACC, S_OUT} state_t;

    localparam logic [3:0] LAST_CNT = 4'(N_TERMS - 1);

    state_t           r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             w_accept;
    logic [ACC_W:0]   w_sum_ext;

    // rst is folded in so no product looks accepted while reset is held
    assign c_ready   = (r_state == S_ACC) & rst;
    assign sum_valid = (r_state == S_OUT);
    assign w_accept  = c_valid & c_ready;
    assign w_sum_ext = {1'b0, r_acc} + (ACC_W+1)'(c_in);

    assign sum       = r_acc;
    assign term_cnt  = r_cnt[2:0];
    assign overflow  = r_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_ACC;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        if (clr) begin
            w_state_nxt = S_ACC;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (w_accept) begin
                        w_cnt_nxt = r_cnt + 4'd1;
`ifdef PRODUCT_ACC_SATURATE_EN
                        // once clamped, stay pinned at max for the rest of the batch
                        if (r_ovf || w_sum_ext[ACC_W]) begin
                            w_acc_nxt = '1;
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_acc_nxt = w_sum_ext[ACC_W-1:0];
                        end
`else
                        w_acc_nxt = w_sum_ext[ACC_W-1:0];
                        if (w_sum_ext[ACC_W]) w_ovf_nxt = 1'b1;
`endif
                        if (r_cnt == LAST_CNT) w_state_nxt = S_OUT;
                    end
                end
                S_OUT: begin
                    if (sum_ready) begin
                        w_state_nxt = S_ACC;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                    end
                end
                default: w_state_nxt = S_ACC;
            endcase
        end
    end

endmodule
